// File: rtl/spike_rate_decoder.sv
// Spike train decoder: per-window spike count and minimum inter-spike interval,
// delivered on a valid/ready result port with a sticky drop flag.
module spike_rate_decoder #(
  parameter int CNT_W = 8,
  parameter int WIN_W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             enable,
  input  logic             spike,
  input  logic [WIN_W-1:0] window_length,
  input  logic             out_ready,
  output logic             out_valid,
  output logic [CNT_W-1:0] spike_count,
  output logic [CNT_W-1:0] min_isi,
  output logic             overrun
);

  typedef enum logic {IDLE, COUNT} state_t;

  state_t           state, state_n;
  logic [WIN_W:0]   win_len, win_len_n;
  logic [WIN_W-1:0] win_ctr, win_ctr_n;
  logic [CNT_W-1:0] acc_count, acc_count_n;
  logic [CNT_W-1:0] acc_min, acc_min_n;
  logic [CNT_W-1:0] isi_ctr, isi_n;
  logic             seen, seen_n;
  logic             valid_n, overrun_n;
  logic [CNT_W-1:0] cnt_out_n, min_out_n;
  logic [CNT_W-1:0] res_count, res_min, isi_p1;
  logic [WIN_W:0]   new_len;
  logic             win_last, done;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] x);
    return (x == '1) ? x : x + 1'b1;
  endfunction

  // zero length encodes the full 2^WIN_W window
  assign new_len  = (window_length == '0) ? {1'b1, {WIN_W{1'b0}}}
                                          : {1'b0, window_length};
  assign win_last = ({1'b0, win_ctr} == win_len - 1'b1);
  assign isi_p1   = sat_inc(isi_ctr);

  always_comb begin
    state_n     = state;
    win_len_n   = win_len;
    win_ctr_n   = win_ctr;
    acc_count_n = acc_count;
    acc_min_n   = acc_min;
    isi_n       = isi_ctr;
    seen_n      = seen;
    valid_n     = out_valid;
    overrun_n   = overrun;
    cnt_out_n   = spike_count;
    min_out_n   = min_isi;
    res_count   = acc_count;
    res_min     = acc_min;
    done        = 1'b0;

    if (out_valid && out_ready) valid_n = 1'b0;

    unique case (state)
      IDLE: begin
        if (enable) begin
          state_n     = COUNT;
          win_len_n   = new_len;
          win_ctr_n   = '0;
          acc_count_n = '0;
          acc_min_n   = '1;
          isi_n       = '0;
          seen_n      = 1'b0;
        end
      end
      COUNT: begin
        if (!enable) begin
          state_n     = IDLE;
          win_ctr_n   = '0;
          acc_count_n = '0;
          acc_min_n   = '1;
          isi_n       = '0;
          seen_n      = 1'b0;
          overrun_n   = 1'b0;
        end else begin
          if (spike) begin
            res_count = sat_inc(acc_count);
            if (seen && (isi_p1 < acc_min)) res_min = isi_p1;
            isi_n  = '0;
            seen_n = 1'b1;
          end else begin
            isi_n = isi_p1;
          end
          if (win_last) begin
            done        = 1'b1;
            win_len_n   = new_len;
            win_ctr_n   = '0;
            acc_count_n = '0;
            acc_min_n   = '1;
            isi_n       = '0;
            seen_n      = 1'b0;
          end else begin
            win_ctr_n   = win_ctr + 1'b1;
            acc_count_n = res_count;
            acc_min_n   = res_min;
          end
        end
      end
    endcase

    if (done) begin
      if (!out_valid || out_ready) begin
        valid_n   = 1'b1;
        cnt_out_n = res_count;
        min_out_n = res_min;
      end else begin
        overrun_n = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      win_len     <= '0;
      win_ctr     <= '0;
      acc_count   <= '0;
      acc_min     <= '0;
      isi_ctr     <= '0;
      seen        <= 1'b0;
      out_valid   <= 1'b0;
      spike_count <= '0;
      min_isi     <= '0;
      overrun     <= 1'b0;
    end else begin
      state       <= state_n;
      win_len     <= win_len_n;
      win_ctr     <= win_ctr_n;
      acc_count   <= acc_count_n;
      acc_min     <= acc_min_n;
      isi_ctr     <= isi_n;
      seen        <= seen_n;
      out_valid   <= valid_n;
      spike_count <= cnt_out_n;
      min_isi     <= min_out_n;
      overrun     <= overrun_n;
    end
  end

endmodule

// File: tb/tb_spike_rate_decoder.sv
// Directed bench for spike_rate_decoder: window vector table plus
// hand-written backpressure, abort and reset sequences.
module tb_spike_rate_decoder;

  logic       clk = 1'b0;
  logic       clk_run = 1'b0;
  logic       rst_n = 1'b1;
  logic       enable = 1'b0;
  logic       spike = 1'b0;
  logic [7:0] window_length = 8'd0;
  logic       out_ready = 1'b0;
  logic       out_valid;
  logic [7:0] spike_count;
  logic [7:0] min_isi;
  logic       overrun;

  int total = 0;
  int bad = 0;

  typedef struct {
    int          len;
    logic [31:0] mask;
    logic [7:0]  cnt;
    logic [7:0]  mn;
  } vec_t;

  vec_t vt[9];

  spike_rate_decoder #(.CNT_W(8), .WIN_W(8)) dut (
    .clk(clk),
    .rst_n(rst_n),
    .enable(enable),
    .spike(spike),
    .window_length(window_length),
    .out_ready(out_ready),
    .out_valid(out_valid),
    .spike_count(spike_count),
    .min_isi(min_isi),
    .overrun(overrun)
  );

  always #5 clk = clk_run ? ~clk : clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d want %0d", nm, act, exp);
    end
  endtask

  task automatic run_win(input int len, input logic [31:0] mask);
    logic [31:0] m;
    m = mask;
    for (int k = 0; k < len; k++) begin
      spike = m[k];
      tick();
    end
    spike = 1'b0;
  endtask

  initial begin
    vt[0] = '{10, 32'h0000_0224, 8'd3, 8'd3};
    vt[1] = '{10, 32'h0000_0000, 8'd0, 8'd255};
    vt[2] = '{8,  32'h0000_0088, 8'd2, 8'd4};
    vt[3] = '{5,  32'h0000_001F, 8'd5, 8'd1};
    vt[4] = '{1,  32'h0000_0001, 8'd1, 8'd255};
    vt[5] = '{1,  32'h0000_0000, 8'd0, 8'd255};
    vt[6] = '{16, 32'h0000_8001, 8'd2, 8'd15};
    vt[7] = '{12, 32'h0000_0832, 8'd4, 8'd1};
    vt[8] = '{32, 32'h8000_0401, 8'd3, 8'd10};

    // async reset with the clock stopped
    #2 rst_n = 1'b0;
    #1;
    chk("rst_valid", out_valid, 0);
    chk("rst_count", spike_count, 0);
    chk("rst_min", min_isi, 0);
    chk("rst_overrun", overrun, 0);
    #2 rst_n = 1'b1;
    clk_run = 1'b1;
    tick();

    // table-driven single windows from IDLE
    for (int i = 0; i < 9; i++) begin
      logic [31:0] m;
      m = vt[i].mask;
      window_length = vt[i].len[7:0];
      enable = 1'b1;
      out_ready = 1'b1;
      tick();
      for (int k = 0; k < vt[i].len; k++) begin
        spike = m[k];
        tick();
        if (k == vt[i].len - 2) chk($sformatf("v%0d_early", i), out_valid, 0);
      end
      spike = 1'b0;
      chk($sformatf("v%0d_valid", i), out_valid, 1);
      chk($sformatf("v%0d_count", i), spike_count, vt[i].cnt);
      chk($sformatf("v%0d_min", i), min_isi, vt[i].mn);
      enable = 1'b0;
      tick();
      chk($sformatf("v%0d_drop", i), out_valid, 0);
    end

    // back-to-back windows
    window_length = 8'd10;
    enable = 1'b1;
    tick();
    run_win(10, 32'h224);
    chk("b2b_valid1", out_valid, 1);
    chk("b2b_count1", spike_count, 3);
    run_win(1, 32'h0);
    chk("b2b_gap", out_valid, 0);
    run_win(9, 32'h0);
    chk("b2b_valid2", out_valid, 1);
    chk("b2b_count2", spike_count, 0);
    chk("b2b_min2", min_isi, 255);
    enable = 1'b0;
    tick();

    // 256-sample window with saturation
    window_length = 8'd0;
    enable = 1'b1;
    tick();
    spike = 1'b1;
    for (int k = 0; k < 255; k++) tick();
    chk("sat_early", out_valid, 0);
    tick();
    spike = 1'b0;
    chk("sat_valid", out_valid, 1);
    chk("sat_count", spike_count, 255);
    chk("sat_min", min_isi, 1);
    enable = 1'b0;
    tick();

    // backpressure over three windows
    window_length = 8'd4;
    out_ready = 1'b0;
    enable = 1'b1;
    tick();
    run_win(4, 32'h1);
    chk("bp1_valid", out_valid, 1);
    chk("bp1_count", spike_count, 1);
    chk("bp1_ovr", overrun, 0);
    run_win(4, 32'h3);
    chk("bp2_count", spike_count, 1);
    chk("bp2_ovr", overrun, 1);
    run_win(4, 32'h7);
    chk("bp3_valid", out_valid, 1);
    chk("bp3_count", spike_count, 1);
    chk("bp3_min", min_isi, 255);
    chk("bp3_ovr", overrun, 1);
    out_ready = 1'b1;
    tick();
    chk("bp_accept", out_valid, 0);
    chk("bp_ovr_hold", overrun, 1);
    enable = 1'b0;
    tick();
    chk("bp_ovr_clr", overrun, 0);

    // window end coincides with a handshake
    out_ready = 1'b0;
    enable = 1'b1;
    tick();
    run_win(4, 32'h3);
    chk("sim_a_count", spike_count, 2);
    chk("sim_a_min", min_isi, 1);
    run_win(3, 32'h1);
    out_ready = 1'b1;
    tick();
    chk("sim_valid", out_valid, 1);
    chk("sim_count", spike_count, 1);
    chk("sim_min", min_isi, 255);
    chk("sim_ovr", overrun, 0);
    tick();
    chk("sim_drop", out_valid, 0);
    enable = 1'b0;
    tick();

    // abort mid-window, then a fresh window
    window_length = 8'd20;
    enable = 1'b1;
    tick();
    run_win(8, 32'h9);
    enable = 1'b0;
    tick();
    chk("abort_valid", out_valid, 0);
    tick();
    tick();
    chk("abort_idle", out_valid, 0);
    enable = 1'b1;
    tick();
    for (int k = 0; k < 20; k++) begin
      spike = (k == 5);
      tick();
      if (k == 18) chk("re_early", out_valid, 0);
    end
    spike = 1'b0;
    chk("re_valid", out_valid, 1);
    chk("re_count", spike_count, 1);
    chk("re_min", min_isi, 255);
    enable = 1'b0;
    tick();

    // reset with a pending result and overrun set
    window_length = 8'd4;
    out_ready = 1'b0;
    enable = 1'b1;
    tick();
    run_win(4, 32'h5);
    chk("mr_count", spike_count, 2);
    chk("mr_min", min_isi, 2);
    run_win(4, 32'h0);
    chk("mr_ovr", overrun, 1);
    run_win(2, 32'h0);
    rst_n = 1'b0;
    #1;
    chk("mr_valid0", out_valid, 0);
    chk("mr_count0", spike_count, 0);
    chk("mr_min0", min_isi, 0);
    chk("mr_ovr0", overrun, 0);
    enable = 1'b0;
    #2 rst_n = 1'b1;
    tick();
    chk("mr_after", out_valid, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
